// File: rtl/alu_control_mc.sv
// Registered ALU control decode for the RISC_KGP datapath, with a busy/stall FSM
// that holds issue for fixed-latency multiply/divide operations.
module alu_control_mc #(
  parameter int                FUNC_W   = 5,
  parameter int                CTRL_W   = 4,
  parameter logic [CTRL_W-1:0] MUL_CODE = 4'b1110,
  parameter logic [CTRL_W-1:0] DIV_CODE = 4'b1111,
  parameter int                MUL_LAT  = 4,
  parameter int                DIV_LAT  = 16,
  parameter int                CNT_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [FUNC_W-1:0] func_code,
  input  logic              flush,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              out_valid,
  output logic              mc_busy,
  output logic              stall
);

  typedef enum logic {
    IDLE   = 1'b0,
    MC_RUN = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  generate
    if (FUNC_W < CTRL_W) begin : g_bad_func_w
      $error("alu_control_mc: FUNC_W must be >= CTRL_W");
    end
    if (MUL_LAT < 2 || DIV_LAT < 2) begin : g_bad_lat
      $error("alu_control_mc: MUL_LAT and DIV_LAT must be >= 2");
    end
    if ((MUL_LAT - 1) >= (1 << CNT_W) || (DIV_LAT - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
      $error("alu_control_mc: CNT_W too narrow for the configured latencies");
    end
  endgenerate

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              ovld_q, ovld_d;
  logic              accept;
  logic              unused_func_bits;

  // Single-cycle classes; class 3 never reaches this decode.
  function automatic logic [CTRL_W-1:0] decode_single(input logic [1:0]        op,
                                                      input logic [FUNC_W-1:0] fc);
    logic [CTRL_W-1:0] res;
    case (op)
      2'd1:    res = fc[CTRL_W-1:0];
      2'd2:    res = CTRL_W'(1);
      default: res = '0;
    endcase
    return res;
  endfunction

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid & in_ready & ~flush;
  assign mc_busy   = (state_q == MC_RUN);
  assign stall     = mc_busy;
  assign alu_ctrl  = ctrl_q;
  assign out_valid = ovld_q;

  assign unused_func_bits = ^func_code;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    ovld_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (alu_op == 2'd3) begin
            state_d = MC_RUN;
            if (func_code[0]) begin
              ctrl_d = DIV_CODE;
              cnt_d  = DIV_CNT;
            end else begin
              ctrl_d = MUL_CODE;
              cnt_d  = MUL_CNT;
            end
          end else begin
            ctrl_d = decode_single(alu_op, func_code);
            ovld_d = 1'b1;
          end
        end
      end
      MC_RUN: begin
        // Flush beats completion, including on the final count.
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
          ctrl_d  = '0;
        end else if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
          ovld_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      ovld_q  <= ovld_d;
    end
  end

endmodule

// File: tb/tb_alu_control_mc.sv
// Directed bench for alu_control_mc: decode classes, multi-cycle latency,
// held requests during busy, flush priority and asynchronous reset.
module tb_alu_control_mc;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] alu_op;
  logic [4:0] func_code;
  logic       flush;
  logic [3:0] alu_ctrl;
  logic       out_valid;
  logic       mc_busy;
  logic       stall;

  int errors = 0;
  int checks = 0;

  alu_control_mc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .func_code (func_code),
    .flush     (flush),
    .alu_ctrl  (alu_ctrl),
    .out_valid (out_valid),
    .mc_busy   (mc_busy),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] ctrl, input logic ov,
                         input logic rdy, input logic stl);
    chk({tag, ".alu_ctrl"},  alu_ctrl,  ctrl);
    chk({tag, ".out_valid"}, out_valid, ov);
    chk({tag, ".in_ready"},  in_ready,  rdy);
    chk({tag, ".stall"},     stall,     stl);
    chk({tag, ".mc_busy"},   mc_busy,   stl);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    alu_op    = 2'd0;
    func_code = 5'd0;
    flush     = 1'b0;

    // Reset state
    step();
    step();
    chk_all("reset", 4'h0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    chk_all("post_reset", 4'h0, 1'b0, 1'b1, 1'b0);

    // Back-to-back single-cycle ops: add, funct, sub
    in_valid = 1'b1; alu_op = 2'd0; func_code = 5'b00000;
    step();
    chk_all("add", 4'h0, 1'b1, 1'b1, 1'b0);
    alu_op = 2'd1; func_code = 5'b00110;
    step();
    chk_all("funct6", 4'h6, 1'b1, 1'b1, 1'b0);
    alu_op = 2'd2; func_code = 5'b00000;
    step();
    chk_all("sub", 4'h1, 1'b1, 1'b1, 1'b0);
    alu_op = 2'd1; func_code = 5'b10011;
    step();
    chk_all("funct_trunc", 4'h3, 1'b1, 1'b1, 1'b0);
    in_valid = 1'b0;
    step();
    chk_all("idle_hold", 4'h3, 1'b0, 1'b1, 1'b0);

    // Multiply: accept at E0, result after E3, new op at E4
    in_valid = 1'b1; alu_op = 2'd3; func_code = 5'b00000;
    step();
    chk_all("mul_e0", 4'hE, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    step();
    chk_all("mul_e1", 4'hE, 1'b0, 1'b0, 1'b1);
    step();
    chk_all("mul_e2", 4'hE, 1'b0, 1'b0, 1'b1);
    step();
    chk_all("mul_e3", 4'hE, 1'b1, 1'b1, 1'b0);
    in_valid = 1'b1; alu_op = 2'd0;
    step();
    chk_all("mul_e4_add", 4'h0, 1'b1, 1'b1, 1'b0);
    in_valid = 1'b0;
    step();
    chk_all("mul_after", 4'h0, 1'b0, 1'b1, 1'b0);

    // Divide with a different op held on in_valid during MC_RUN
    in_valid = 1'b1; alu_op = 2'd3; func_code = 5'b00001;
    step();
    chk_all("div_e0", 4'hF, 1'b0, 1'b0, 1'b1);
    alu_op = 2'd2; func_code = 5'b00110;
    for (int i = 1; i < 15; i++) begin
      step();
      chk_all($sformatf("div_e%0d", i), 4'hF, 1'b0, 1'b0, 1'b1);
    end
    step();
    chk_all("div_e15", 4'hF, 1'b1, 1'b1, 1'b0);
    step();
    chk_all("div_e16_sub", 4'h1, 1'b1, 1'b1, 1'b0);
    in_valid = 1'b0;
    step();
    chk_all("div_after", 4'h1, 1'b0, 1'b1, 1'b0);

    // Flush on the final count of a multiply
    in_valid = 1'b1; alu_op = 2'd3; func_code = 5'b00000;
    step();
    chk_all("fl_mul_e0", 4'hE, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    step();
    step();
    chk_all("fl_mul_e2", 4'hE, 1'b0, 1'b0, 1'b1);
    flush = 1'b1;
    step();
    chk_all("fl_mul_e3", 4'h0, 1'b0, 1'b1, 1'b0);
    flush = 1'b0;
    step();
    chk_all("fl_mul_e4", 4'h0, 1'b0, 1'b1, 1'b0);

    // Flush in IDLE blocks the accept and holds alu_ctrl
    in_valid = 1'b1; alu_op = 2'd2;
    step();
    chk_all("pre_fl_sub", 4'h1, 1'b1, 1'b1, 1'b0);
    alu_op = 2'd1; func_code = 5'b00110; flush = 1'b1;
    step();
    chk_all("fl_idle", 4'h1, 1'b0, 1'b1, 1'b0);
    alu_op = 2'd3; func_code = 5'b00000;
    step();
    chk_all("fl_idle_mc", 4'h1, 1'b0, 1'b1, 1'b0);
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk_all("fl_idle_after", 4'h1, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset between edges during a divide
    in_valid = 1'b1; alu_op = 2'd3; func_code = 5'b00001;
    step();
    chk_all("ar_div_e0", 4'hF, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    chk_all("ar_async", 4'h0, 1'b0, 1'b1, 1'b0);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk_all($sformatf("ar_post%0d", i), 4'h0, 1'b0, 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
